sipo_deserializer: RTL and testbench

Serial-in/parallel-out receiver: the receive end of the serial link driven by the team's PISO shift register. It detects a start bit, shifts WIDTH data bits MSB-first, checks a stop bit, and presents the captured word on a parallel bus with a one-cycle valid strobe. It sits on the far side of the serial wire and feeds parallel consumers (registers, FIFOs).

---
 rtl/sipo_deserializer.sv | 89 ++++++++
 tb/tb_sipo_deserializer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out frame receiver: start bit (1), WIDTH data bits MSB-first, stop bit (0).
// A captured word is presented on p_out with a one-cycle data_valid strobe; bad stop bits pulse frame_err.
module sipo_deserializer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serial_in,
  input  logic             en,
  output logic [WIDTH-1:0] p_out,
  output logic             data_valid,
  output logic             frame_err,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    STOP  = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] shreg, shreg_nx;
  logic [WIDTH-1:0] p_out_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic             dv_nx, fe_nx;

  always_comb begin
    state_nx = state;
    shreg_nx = shreg;
    cnt_nx   = cnt;
    p_out_nx = p_out;
    dv_nx    = 1'b0;
    fe_nx    = 1'b0;
    if (en) begin
      case (state)
        IDLE: begin
          if (serial_in) begin
            state_nx = SHIFT;
            cnt_nx   = '0;
          end
        end
        SHIFT: begin
          shreg_nx = {shreg[WIDTH-2:0], serial_in};
          // Counter saturates at WIDTH-1; the last data bit moves us to STOP.
          if (cnt == CW'(WIDTH - 1)) begin
            state_nx = STOP;
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
        STOP: begin
          // A 1 here is a framing error, never a fresh start bit.
          if (serial_in) begin
            fe_nx = 1'b1;
          end else begin
            p_out_nx = shreg;
            dv_nx    = 1'b1;
          end
          state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= '0;
      cnt        <= '0;
      p_out      <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nx;
      shreg      <= shreg_nx;
      cnt        <= cnt_nx;
      p_out      <= p_out_nx;
      data_valid <= dv_nx;
      frame_err  <= fe_nx;
      busy       <= (state_nx != IDLE);
    end
  end

endmodule

// File: tb/tb_sipo_deserializer.sv
// Bench for sipo_deserializer: directed frames from the test plan plus random traffic,
// compared every cycle against a queue-based frame model.
module tb_sipo_deserializer;
  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         serial_in;
  logic         en;
  logic [W-1:0] p_out;
  logic         data_valid;
  logic         frame_err;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int dv_seen = 0;
  int fe_seen = 0;

  // Reference model: frame progress is just "inside a frame" plus the data bits collected so far.
  bit           in_frame;
  bit           bits_q[$];
  logic [W-1:0] m_pout;
  logic         m_dv;
  logic         m_fe;
  logic [W-1:0] exp_q[$];

  sipo_deserializer #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .serial_in  (serial_in),
    .en         (en),
    .p_out      (p_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic e, input logic s);
    logic [W-1:0] w;
    if (r) begin
      in_frame = 0;
      bits_q.delete();
      m_pout = '0;
      m_dv   = 1'b0;
      m_fe   = 1'b0;
      exp_q.delete();
    end else begin
      m_dv = 1'b0;
      m_fe = 1'b0;
      if (e) begin
        if (!in_frame) begin
          if (s) begin
            in_frame = 1;
            bits_q.delete();
          end
        end else if (bits_q.size() < W) begin
          bits_q.push_back(s);
        end else begin
          if (!s) begin
            for (int i = 0; i < W; i++) w[W-1-i] = bits_q[i];
            m_pout = w;
            m_dv   = 1'b1;
            exp_q.push_back(w);
          end else begin
            m_fe = 1'b1;
          end
          in_frame = 0;
        end
      end
    end
  endtask

  // One clock: drive on the falling edge, let the DUT sample, then compare just after the rising edge.
  task automatic step(input logic r, input logic e, input logic s);
    logic [W-1:0] w;
    @(negedge clk);
    rst       = r;
    en        = e;
    serial_in = s;
    @(posedge clk);
    model_edge(r, e, s);
    #1;
    check("data_valid", data_valid, m_dv);
    check("frame_err", frame_err, m_fe);
    check("p_out", p_out, m_pout);
    check("busy", busy, in_frame);
    if (data_valid === 1'b1) begin
      dv_seen++;
      if (exp_q.size() == 0) begin
        check("sb_unexpected_word", 1, 0);
      end else begin
        w = exp_q.pop_front();
        check("sb_word", p_out, w);
      end
    end
    if (frame_err === 1'b1) fe_seen++;
  endtask

  task automatic send(input logic [15:0] bits, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b1, bits[n-1-i]);
      for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; serial_in = 1'b1;
    in_frame = 0; m_pout = '0; m_dv = 0; m_fe = 0;

    // Reset with an active-looking line
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    check("reset_pout", p_out, 4'b0000);
    check("reset_busy", busy, 1'b0);

    // Basic frame
    dv_seen = 0;
    send(16'b110010, 6, 0);
    check("basic_pout", p_out, 4'b1001);
    check("basic_dv_count", dv_seen, 1);
    step(1'b0, 1'b1, 1'b0);
    check("basic_idle_busy", busy, 1'b0);
    check("basic_dv_drop", data_valid, 1'b0);

    // Same frame with gapped enable
    dv_seen = 0;
    send(16'b110010, 6, 3);
    check("gap_pout", p_out, 4'b1001);
    check("gap_dv_count", dv_seen, 1);

    // Framing error keeps the previous word
    dv_seen = 0; fe_seen = 0;
    send(16'b101101, 6, 0);
    check("ferr_count", fe_seen, 1);
    check("ferr_dv_count", dv_seen, 0);
    check("ferr_pout", p_out, 4'b1001);
    check("ferr_busy", busy, 1'b0);

    // Back-to-back frames
    dv_seen = 0;
    send(16'b101100, 6, 0);
    check("b2b_pout1", p_out, 4'b0110);
    send(16'b111110, 6, 0);
    check("b2b_pout2", p_out, 4'b1111);
    check("b2b_dv_count", dv_seen, 2);

    // Reset mid-frame drops the partial frame
    dv_seen = 0;
    send(16'b110, 3, 0);
    step(1'b1, 1'b1, 1'b0);
    check("midrst_pout", p_out, 4'b0000);
    send(16'b100110, 6, 0);
    check("midrst_pout_after", p_out, 4'b0011);
    check("midrst_dv_count", dv_seen, 1);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
           1'($urandom_range(0, 1)));
    end
    check("sb_leftover", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
